// File: rtl/vec_alu_pkg.sv
// Shared types and default sizing for the vector execute units.
package vec_alu_pkg;

  localparam int unsigned VEC_N     = 8;
  localparam int unsigned VEC_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vmul_state_t;

endpackage

// File: rtl/vmul_lane_unit.sv
// One lane of the vector multiply: signed product, overflow detect, wrap/saturate select.
module vmul_lane_unit
  import vec_alu_pkg::*;
#(
  parameter int unsigned N = VEC_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sat_en,
  input  logic         en,
  output logic [N-1:0] result_c,
  output logic         ovf_c
);

  localparam int unsigned PW = 2 * N;

  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod;
  logic [N:0]    top;
  logic          wide_ovf;

  // Sign-extend to full width so the low 2N bits of the product are the signed product.
  always_comb begin
    a_x      = {{N{a[N-1]}}, a};
    b_x      = {{N{b[N-1]}}, b};
    prod     = a_x * b_x;
    top      = prod[PW-1:N-1];
    wide_ovf = !((&top) || !(|top));
    result_c = '0;
    ovf_c    = 1'b0;
    if (en) begin
      ovf_c = wide_ovf;
      if (sat_en && wide_ovf) begin
        result_c = prod[PW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
        result_c = prod[N-1:0];
      end
    end
  end

endmodule

// File: rtl/vec_mul_sequencer.sv
// Shares one lane multiplier across all lanes of a vector multiply, one lane per cycle.
module vec_mul_sequencer
  import vec_alu_pkg::*;
#(
  parameter int unsigned N     = VEC_N,
  parameter int unsigned LANES = VEC_LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [LANES*N-1:0] vec_a,
  input  logic [LANES*N-1:0] vec_b,
  input  logic [LANES-1:0]   lane_mask,
  input  logic               sat_en,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LANES*N-1:0] vec_out,
  output logic [LANES-1:0]   ovf_lane,
  output logic               ovf_any,
  output logic               busy
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LAST  = LANES - 1;

  vmul_state_t               state;
  logic [IDX_W-1:0]          idx;
  logic [LANES-1:0][N-1:0]   op_a;
  logic [LANES-1:0][N-1:0]   op_b;
  logic [LANES-1:0][N-1:0]   res_q;
  logic [LANES-1:0]          mask_q;
  logic                      sat_q;
  logic [N-1:0]              lane_res;
  logic                      lane_ovf;

  vmul_lane_unit #(.N(N)) u_lane (
    .a        (op_a[idx]),
    .b        (op_b[idx]),
    .sat_en   (sat_q),
    .en       (mask_q[idx]),
    .result_c (lane_res),
    .ovf_c    (lane_ovf)
  );

  assign vec_out = res_q;

  // Sequencer FSM: accept operands, step lanes, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      mask_q      <= '0;
      sat_q       <= 1'b0;
      res_q       <= '0;
      ovf_lane    <= '0;
      ovf_any     <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start_ready <= 1'b1;
          if (start_valid && start_ready) begin
            op_a        <= vec_a;
            op_b        <= vec_b;
            mask_q      <= lane_mask;
            sat_q       <= sat_en;
            res_q       <= '0;
            ovf_lane    <= '0;
            ovf_any     <= 1'b0;
            idx         <= '0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          res_q[idx]    <= lane_res;
          ovf_lane[idx] <= lane_ovf;
          ovf_any       <= ovf_any | lane_ovf;
          if (idx == IDX_W'(LAST)) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
